mux_sel_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the team's 6:1 4-bit data mux and drives its 3-bit select.
- Six sources each present a request. The block grants one source and holds the mux select on it for a burst of beats under a valid/ready handshake.
- It pulses a per-source ack for every accepted beat.
- The downstream consumer samples the mux output whenever out_valid && out_ready.

---
 rtl/mux_sel_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 6:1 data mux with burst/handshake control.
// Define MUX_SEL_FIXED_PRIO_EN to switch arbitration to fixed priority (lowest index wins).
module mux_sel_arbiter #(
  parameter int         BURST_LEN = 4,
  parameter logic [2:0] IDLE_SEL  = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] req,
  output logic [2:0] sel,
  output logic [5:0] grant,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] ack,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t     state, state_n;
  logic [2:0] sel_n;
  logic [3:0] beat_cnt, beat_cnt_n;
  logic [2:0] last_grant, last_grant_n;

  logic [5:0] sel_onehot;
  logic       req_sel;
  logic       handshake;
  logic       win_found;
  logic [2:0] win_idx;

  // Arbitration winner, evaluated every cycle but only consumed in IDLE.
`ifdef MUX_SEL_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end
`else
  logic [2:0] cand;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = last_grant;
    for (int i = 0; i < 6; i++) begin
      cand = (cand == 3'd5) ? 3'd0 : cand + 3'd1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // The one-hot form avoids indexing req with the out-of-range idle select.
  assign sel_onehot = (state == XFER) ? (6'b000001 << sel) : 6'b000000;
  assign req_sel    = |(req & sel_onehot);

  assign busy      = (state == XFER);
  assign grant     = sel_onehot;
  assign out_valid = resetn && busy && req_sel;
  assign handshake = out_valid && out_ready;
  assign ack       = handshake ? sel_onehot : 6'b000000;

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    beat_cnt_n   = beat_cnt;
    last_grant_n = last_grant;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n    = XFER;
          sel_n      = win_idx;
          beat_cnt_n = 4'd0;
        end
      end

      XFER: begin
        // Release when the source runs dry or its last permitted beat is accepted.
        if (!req_sel || (handshake && beat_cnt == LAST_BEAT)) begin
          state_n      = IDLE;
          last_grant_n = sel;
          sel_n        = IDLE_SEL;
          beat_cnt_n   = 4'd0;
        end else if (handshake) begin
          beat_cnt_n = beat_cnt + 4'd1;
        end
      end

      default: begin
        state_n = IDLE;
        sel_n   = IDLE_SEL;
      end
    endcase
  end

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      sel        <= IDLE_SEL;
      beat_cnt   <= 4'd0;
      last_grant <= 3'd5;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      beat_cnt   <= beat_cnt_n;
      last_grant <= last_grant_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: per-cycle output checks plus an ack scoreboard.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] req;
  logic [2:0] sel;
  logic [5:0] grant;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] ack;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ack_q[$];
  int mon_src;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.BURST_LEN(4), .IDLE_SEL(3'b111)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .busy      (busy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Expected {sel, grant, out_valid, busy} for a given select (7 = idle) and valid.
  function automatic logic [10:0] exp_vec(int s, logic ov);
    logic [5:0] g;
    g = (s == 7) ? 6'b000000 : 6'(1 << s);
    return {3'(s), g, ov, (s != 7)};
  endfunction

  // Ack scoreboard: every nonzero ack must match the oldest expected source.
  always @(negedge clk) begin
    if (mon_en && ack !== 6'b000000) begin
      vectors++;
      if (exp_ack_q.size() == 0) begin
        miscompares++;
        $display("FAIL ack_unexpected: ack=%b, expected no ack", ack);
      end else begin
        mon_src = exp_ack_q.pop_front();
        if (ack !== 6'(1 << mon_src)) begin
          miscompares++;
          $display("FAIL ack_order: ack=%b, expected %b", ack, 6'(1 << mon_src));
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0; req = 6'b111111; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      vectors++;
      if ({sel, grant, out_valid, busy} !== exp_vec(7, 1'b0) || ack !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold c%0d: sel=%0d grant=%b ov=%b busy=%b ack=%b, expected sel=7 all zero",
                 c, sel, grant, out_valid, busy, ack);
      end
      next_cycle();
    end
    resetn = 1'b1; out_ready = 1'b0;
    sample();
    vectors++;
    if ({sel, grant, out_valid, busy} !== exp_vec(7, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_release_idle: sel=%0d grant=%b ov=%b busy=%b, expected idle", sel, grant, out_valid, busy);
    end
    next_cycle();
    sample();
    vectors++;
    if ({sel, grant, out_valid, busy} !== exp_vec(0, 1'b1) || ack !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_first_grant: sel=%0d grant=%b ov=%b busy=%b ack=%b, expected sel=0 ov=1 ack=0",
               sel, grant, out_valid, busy, ack);
    end
    next_cycle();
    resetn = 1'b0; req = 6'b000000;
    next_cycle();
    resetn = 1'b1;
    sample();
    vectors++;
    if ({sel, grant, out_valid, busy} !== exp_vec(7, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_cleanup: sel=%0d grant=%b, expected idle", sel, grant);
    end
    next_cycle();
    mon_en = 1'b1;
  endtask

  task automatic check_queue_empty(string name);
    vectors++;
    if (exp_ack_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_acks_missing: %0d acks outstanding, expected 0", name, exp_ack_q.size());
      exp_ack_q.delete();
    end
  endtask

`ifndef MUX_SEL_FIXED_PRIO_EN
  task automatic test_round_robin();
    int es[21] = '{7, 0, 0, 0, 0, 7, 2, 2, 2, 2, 7, 5, 5, 5, 5, 7, 0, 0, 0, 0, 7};
    int order[4] = '{0, 2, 5, 0};
    foreach (order[g]) for (int b = 0; b < 4; b++) exp_ack_q.push_back(order[g]);
    req = 6'b100101; out_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (c == 20) req = 6'b000000;
      sample();
      vectors++;
      if ({sel, grant, out_valid, busy} !== exp_vec(es[c], es[c] != 7)) begin
        miscompares++;
        $display("FAIL rr c%0d: sel=%0d grant=%b ov=%b busy=%b, expected sel=%0d",
                 c, sel, grant, out_valid, busy, es[c]);
      end
      next_cycle();
    end
    check_queue_empty("rr");
  endtask

  task automatic test_early_drop();
    int es[8]      = '{7, 1, 1, 1, 7, 2, 2, 7};
    logic eov[8]   = '{0, 1, 1, 0, 0, 1, 0, 0};
    exp_ack_q.push_back(1);
    exp_ack_q.push_back(1);
    req = 6'b000010; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) req = 6'b000000;
      if (c == 4) begin req = 6'b000110; out_ready = 1'b0; end
      if (c == 6) req = 6'b000000;
      sample();
      vectors++;
      if ({sel, grant, out_valid, busy} !== exp_vec(es[c], eov[c])) begin
        miscompares++;
        $display("FAIL early_drop c%0d: sel=%0d grant=%b ov=%b busy=%b, expected sel=%0d ov=%b",
                 c, sel, grant, out_valid, busy, es[c], eov[c]);
      end
      if (c == 3) begin
        vectors++;
        if (ack !== 6'b0) begin
          miscompares++;
          $display("FAIL early_drop_no_ack: ack=%b, expected 000000", ack);
        end
      end
      next_cycle();
    end
    check_queue_empty("early_drop");
  endtask
`else
  task automatic test_fixed_prio();
    int es[16] = '{7, 1, 1, 1, 1, 7, 1, 1, 1, 1, 7, 1, 1, 1, 1, 7};
    for (int b = 0; b < 12; b++) exp_ack_q.push_back(1);
    req = 6'b001010; out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 15) req = 6'b000000;
      sample();
      vectors++;
      if ({sel, grant, out_valid, busy} !== exp_vec(es[c], es[c] != 7)) begin
        miscompares++;
        $display("FAIL fixed_prio c%0d: sel=%0d grant=%b ov=%b, expected sel=%0d", c, sel, grant, out_valid, es[c]);
      end
      next_cycle();
    end
    check_queue_empty("fixed_prio");
  endtask
`endif

  task automatic test_backpressure();
    int es[9] = '{7, 3, 3, 3, 3, 3, 3, 3, 7};
    for (int b = 0; b < 4; b++) exp_ack_q.push_back(3);
    req = 6'b001000; out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) out_ready = 1'b1;
      if (c == 8) req = 6'b000000;
      sample();
      vectors++;
      if ({sel, grant, out_valid, busy} !== exp_vec(es[c], es[c] != 7)) begin
        miscompares++;
        $display("FAIL backpressure c%0d: sel=%0d grant=%b ov=%b busy=%b, expected sel=%0d",
                 c, sel, grant, out_valid, busy, es[c]);
      end
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (ack !== 6'b0) begin
          miscompares++;
          $display("FAIL backpressure_stall_ack c%0d: ack=%b, expected 000000", c, ack);
        end
      end
      next_cycle();
    end
    check_queue_empty("backpressure");
  endtask

  task automatic test_reset_mid_burst();
    int es[7]    = '{7, 4, 0, 7, 1, 1, 7};
    logic eov[7] = '{0, 1, 0, 0, 1, 0, 0};
    exp_ack_q.push_back(4);
    req = 6'b010000; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin resetn = 1'b0; req = 6'b010110; end
      if (c == 3) begin resetn = 1'b1; out_ready = 1'b0; end
      if (c == 5) req = 6'b000000;
      sample();
      vectors++;
      if (c == 2) begin
        if (out_valid !== 1'b0 || ack !== 6'b0) begin
          miscompares++;
          $display("FAIL mid_reset_cycle: ov=%b ack=%b, expected 0 and 000000", out_valid, ack);
        end
      end else if ({sel, grant, out_valid, busy} !== exp_vec(es[c], eov[c])) begin
        miscompares++;
        $display("FAIL mid_reset c%0d: sel=%0d grant=%b ov=%b busy=%b, expected sel=%0d ov=%b",
                 c, sel, grant, out_valid, busy, es[c], eov[c]);
      end
      next_cycle();
    end
    check_queue_empty("mid_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifndef MUX_SEL_FIXED_PRIO_EN
    test_round_robin();
    test_backpressure();
    test_early_drop();
`else
    test_fixed_prio();
    test_backpressure();
`endif
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
